bdes_fifo: RTL and testbench

- Serial-to-parallel receive stage. It sits directly downstream of the byte serializer (bser).
- It samples the LSB-first serial stream while en is high and reassembles WIDTH-bit words.
- Completed words go into a small output FIFO, drained by a valid/ready consumer.
- It also reports a one-cycle completion pulse and a sticky overrun flag.

---
 rtl/bdes_fifo_if.sv | 21 ++
 rtl/bdes_fifo.sv | 106 ++++++++++
 tb/tb_bdes_fifo.sv | 333 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bdes_fifo_if.sv
// bdes_fifo_if: consumer-side valid/ready bus of the deserializer FIFO.
// out_data/out_valid are driven by the master; out_ready by the slave.
interface bdes_fifo_if #(
   parameter int WIDTH = 8
) ();
   logic [WIDTH-1:0] out_data;
   logic             out_valid;
   logic             out_ready;

   modport master (
      output out_data,
      output out_valid,
      input  out_ready
   );

   modport slave (
      input  out_data,
      input  out_valid,
      output out_ready
   );
endinterface

// File: rtl/bdes_fifo.sv
// bdes_fifo: LSB-first serial-to-parallel receiver feeding a small FIFO.
// Ports: clk, rst_n, en/in serial, bus (out_data/valid/ready), count,
// byte_done pulse, sticky overrun with ovr_clr.
module bdes_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       en,
   input  logic                       in,
   bdes_fifo_if.master                bus,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       byte_done,
   output logic                       overrun,
   input  logic                       ovr_clr
);
   localparam int BW = $clog2(WIDTH);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   logic [BW-1:0]    bcnt;
   logic             en_q;
   logic [WIDTH-2:0] shreg;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    head;
   logic [PW-1:0]    tail;

   logic             start;
   logic [BW-1:0]    idx;
   logic             done;
   logic [WIDTH-1:0] word;
   logic             full;
   logic             pop;
   logic             wr;
   logic             drop;

   // A rising en always restarts at bit 0, discarding any partial word.
   always_comb begin
      start = en && !en_q;
      idx   = start ? '0 : bcnt;
      done  = en && (idx == BW'(WIDTH-1));
      word  = {in, shreg};
      full  = (count == CW'(DEPTH));
      pop   = bus.out_valid && bus.out_ready;
      // At full, a simultaneous pop frees the slot for the new word.
      wr    = done && (!full || pop);
      drop  = done && full && !pop;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bcnt  <= '0;
         en_q  <= 1'b0;
         shreg <= '0;
      end else begin
         en_q <= en;
         if (en) begin
            if (done) begin
               bcnt <= '0;
            end else begin
               bcnt <= idx + 1'b1;
               for (int i = 0; i < WIDTH-1; i++) begin
                  if (idx == BW'(i)) shreg[i] <= in;
               end
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         if (wr) begin
            mem[tail] <= word;
            tail      <= tail + 1'b1;
         end
         if (pop) head <= head + 1'b1;
         unique case ({wr, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Drop sets overrun and outranks a same-cycle clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         byte_done <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         byte_done <= done;
         if (drop)         overrun <= 1'b1;
         else if (ovr_clr) overrun <= 1'b0;
      end
   end

   assign bus.out_data  = mem[head];
   assign bus.out_valid = (count != '0);
endmodule

// File: tb/tb_bdes_fifo.sv
// tb_bdes_fifo: directed self-checking bench for bdes_fifo.
// Scenario tasks run in sequence; checks sample on the falling edge.
module tb_bdes_fifo;
   localparam int WIDTH = 8;
   localparam int DEPTH = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       en = 1'b0;
   logic       in = 1'b0;
   logic       out_ready = 1'b0;
   logic       ovr_clr = 1'b0;
   logic [2:0] count;
   logic       byte_done;
   logic       overrun;

   int n_chk = 0;
   int n_fail = 0;
   int bd_cnt = 0;
   int cyc = 0;
   int max_count = 0;
   logic [7:0] log_d [$];
   int         log_c [$];

   bdes_fifo_if #(.WIDTH(WIDTH)) bus ();
   assign bus.out_ready = out_ready;

   bdes_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .en(en),
      .in(in),
      .bus(bus),
      .count(count),
      .byte_done(byte_done),
      .overrun(overrun),
      .ovr_clr(ovr_clr)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc = cyc + 1;
      if (byte_done) bd_cnt = bd_cnt + 1;
      if (int'(count) > max_count) max_count = int'(count);
      if (bus.out_valid && out_ready) begin
         log_d.push_back(bus.out_data);
         log_c.push_back(cyc);
      end
   end

   task automatic do_reset();
      rst_n = 1'b0;
      en = 1'b0;
      in = 1'b0;
      out_ready = 1'b0;
      ovr_clr = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic send_bits(input logic [7:0] w, input logic rdy_last);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         en = 1'b1;
         in = w[i];
         if (i == 7) out_ready = rdy_last;
      end
   endtask

   task automatic send_word(input logic [7:0] w);
      send_bits(w, 1'b0);
      @(negedge clk);
      en = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      n_chk++;
      if (count !== 3'd0) begin
         n_fail++;
         $display("FAIL rst_count: got %0d want 0", count);
      end
      n_chk++;
      if (bus.out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_valid: got %b want 0", bus.out_valid);
      end
      n_chk++;
      if (bus.out_data !== 8'h00) begin
         n_fail++;
         $display("FAIL rst_data: got %h want 00", bus.out_data);
      end
      n_chk++;
      if ({byte_done, overrun} !== 2'b00) begin
         n_fail++;
         $display("FAIL rst_flags: got %b want 00", {byte_done, overrun});
      end
   endtask

   task automatic test_single();
      do_reset();
      send_bits(8'hA5, 1'b0);
      n_chk++;
      if (bus.out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL single_early: got %b want 0", bus.out_valid);
      end
      @(negedge clk);
      en = 1'b0;
      n_chk++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 8'hA5) begin
         n_fail++;
         $display("FAIL single_word: got %b/%h want 1/a5",
                  bus.out_valid, bus.out_data);
      end
      n_chk++;
      if (count !== 3'd1) begin
         n_fail++;
         $display("FAIL single_count: got %0d want 1", count);
      end
      n_chk++;
      if (byte_done !== 1'b1) begin
         n_fail++;
         $display("FAIL single_bd_hi: got %b want 1", byte_done);
      end
      @(negedge clk);
      n_chk++;
      if (byte_done !== 1'b0) begin
         n_fail++;
         $display("FAIL single_bd_lo: got %b want 0", byte_done);
      end
   endtask

   task automatic test_restart();
      int bd0;
      do_reset();
      bd0 = bd_cnt;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         en = 1'b1;
         in = 1'b1;
      end
      @(negedge clk);
      en = 1'b0;
      @(negedge clk);
      send_word(8'h3C);
      @(negedge clk);
      n_chk++;
      if (count !== 3'd1 || bus.out_data !== 8'h3C) begin
         n_fail++;
         $display("FAIL restart_word: got %0d/%h want 1/3c",
                  count, bus.out_data);
      end
      n_chk++;
      if (bd_cnt - bd0 !== 1) begin
         n_fail++;
         $display("FAIL restart_bd: got %0d want 1", bd_cnt - bd0);
      end
   endtask

   task automatic test_overflow();
      int bd0;
      logic [7:0] w;
      do_reset();
      bd0 = bd_cnt;
      for (int k = 1; k <= 5; k++) begin
         w = 8'(k);
         send_word(w);
      end
      @(negedge clk);
      n_chk++;
      if (count !== 3'd4 || overrun !== 1'b1) begin
         n_fail++;
         $display("FAIL ovf_state: got %0d/%b want 4/1", count, overrun);
      end
      n_chk++;
      if (bd_cnt - bd0 !== 5) begin
         n_fail++;
         $display("FAIL ovf_bd: got %0d want 5", bd_cnt - bd0);
      end
      for (int k = 1; k <= 4; k++) begin
         w = 8'(k);
         n_chk++;
         if (bus.out_valid !== 1'b1 || bus.out_data !== w) begin
            n_fail++;
            $display("FAIL ovf_drain%0d: got %b/%h want 1/%h",
                     k, bus.out_valid, bus.out_data, w);
         end
         out_ready = 1'b1;
         @(negedge clk);
         out_ready = 1'b0;
      end
      n_chk++;
      if (bus.out_valid !== 1'b0 || overrun !== 1'b1) begin
         n_fail++;
         $display("FAIL ovf_empty: got %b/%b want 0/1",
                  bus.out_valid, overrun);
      end
      ovr_clr = 1'b1;
      @(negedge clk);
      ovr_clr = 1'b0;
      n_chk++;
      if (overrun !== 1'b0) begin
         n_fail++;
         $display("FAIL ovf_clr: got %b want 0", overrun);
      end
   endtask

   task automatic test_full_pushpop();
      logic [7:0] exp [4];
      exp = '{8'h22, 8'h33, 8'h44, 8'h77};
      do_reset();
      send_word(8'h11);
      send_word(8'h22);
      send_word(8'h33);
      send_word(8'h44);
      send_bits(8'h77, 1'b1);
      @(negedge clk);
      en = 1'b0;
      out_ready = 1'b0;
      n_chk++;
      if (count !== 3'd4 || overrun !== 1'b0) begin
         n_fail++;
         $display("FAIL pp_state: got %0d/%b want 4/0", count, overrun);
      end
      for (int k = 0; k < 4; k++) begin
         n_chk++;
         if (bus.out_valid !== 1'b1 || bus.out_data !== exp[k]) begin
            n_fail++;
            $display("FAIL pp_drain%0d: got %b/%h want 1/%h",
                     k, bus.out_valid, bus.out_data, exp[k]);
         end
         out_ready = 1'b1;
         @(negedge clk);
         out_ready = 1'b0;
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      send_word(8'h12);
      send_word(8'h34);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         en = 1'b1;
         in = 1'b1;
      end
      @(negedge clk);
      n_chk++;
      if (count !== 3'd2) begin
         n_fail++;
         $display("FAIL ar_pre: got %0d want 2", count);
      end
      #2;
      rst_n = 1'b0;
      en = 1'b0;
      #1;
      n_chk++;
      if (count !== 3'd0 || bus.out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL ar_now: got %0d/%b want 0/0",
                  count, bus.out_valid);
      end
      @(negedge clk);
      rst_n = 1'b1;
      send_word(8'hC3);
      n_chk++;
      if (count !== 3'd1 || bus.out_data !== 8'hC3) begin
         n_fail++;
         $display("FAIL ar_after: got %0d/%h want 1/c3",
                  count, bus.out_data);
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] exp [3];
      exp = '{8'hFF, 8'h00, 8'h81};
      do_reset();
      out_ready = 1'b1;
      log_d.delete();
      log_c.delete();
      max_count = 0;
      send_bits(8'hFF, 1'b1);
      send_bits(8'h00, 1'b1);
      send_bits(8'h81, 1'b1);
      @(negedge clk);
      en = 1'b0;
      repeat (3) @(negedge clk);
      n_chk++;
      if (log_d.size() !== 3) begin
         n_fail++;
         $display("FAIL b2b_num: got %0d want 3", log_d.size());
      end else begin
         for (int k = 0; k < 3; k++) begin
            n_chk++;
            if (log_d[k] !== exp[k]) begin
               n_fail++;
               $display("FAIL b2b_word%0d: got %h want %h",
                        k, log_d[k], exp[k]);
            end
         end
         for (int k = 1; k < 3; k++) begin
            n_chk++;
            if (log_c[k] - log_c[k-1] !== 8) begin
               n_fail++;
               $display("FAIL b2b_gap%0d: got %0d want 8",
                        k, log_c[k] - log_c[k-1]);
            end
         end
      end
      n_chk++;
      if (max_count > 1 || overrun !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_occ: got %0d/%b want <=1/0",
                  max_count, overrun);
      end
      out_ready = 1'b0;
   endtask

   initial begin
      test_reset();
      test_single();
      test_restart();
      test_overflow();
      test_full_pushpop();
      test_async_reset();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end
endmodule
